// File: rtl/mac_seq_ctrl.sv
// ============================================================================
// Module   : mac_seq_ctrl
// Purpose  : Sequences operand beats into an external combinational MAC and
//            accumulates the products of one job into a single result.
//            Define ACC_SATURATE_EN to clamp the result instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl #(
    parameter int bw      = 8,
    parameter int pr      = 8,
    parameter int bw_psum = 2*bw+6,
    parameter int bw_out  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           num_chunks,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [pr*bw-1:0]     a_vec,
    input  logic [pr*bw-1:0]     b_vec,
    output logic [pr*bw-1:0]     mac_a,
    output logic [pr*bw-1:0]     mac_b,
    input  logic [bw_psum-1:0]   mac_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bw_out-1:0]    out_psum,
    output logic                 busy
);

    localparam int ACC_W = bw_psum + 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          n_q, n_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                stage_q, stage_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [pr*bw-1:0]    mac_a_q, mac_a_d;
    logic [pr*bw-1:0]    mac_b_q, mac_b_d;
    logic [bw_out-1:0]   out_psum_q, out_psum_d;

    logic [ACC_W-1:0]    w_acc_sum;
    logic [3:0]          w_cnt_inc;
    logic [bw_out-1:0]   w_res;

    // The product of a beat arrives one cycle after the beat is registered.
    always_comb begin
        w_acc_sum = acc_q;
        if (stage_q) begin
            w_acc_sum = acc_q + {{(ACC_W-bw_psum){mac_out[bw_psum-1]}}, mac_out};
        end
    end

    assign w_cnt_inc = cnt_q + 4'd1;

`ifdef ACC_SATURATE_EN
    logic [ACC_W-bw_out:0] w_top;
    assign w_top = w_acc_sum[ACC_W-1:bw_out-1];

    // Result fits when every bit above the output sign bit repeats it.
    always_comb begin
        if ((&w_top) || (~|w_top)) begin
            w_res = w_acc_sum[bw_out-1:0];
        end else begin
            w_res = {w_acc_sum[ACC_W-1], {(bw_out-1){~w_acc_sum[ACC_W-1]}}};
        end
    end
`else
    assign w_res = w_acc_sum[bw_out-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        stage_d    = 1'b0;
        acc_d      = w_acc_sum;
        mac_a_d    = mac_a_q;
        mac_b_d    = mac_b_q;
        out_psum_d = out_psum_q;

        case (state_q)
            S_IDLE: begin
                if (start && (num_chunks != 4'd0)) begin
                    state_d = S_ACC;
                    n_d     = num_chunks;
                    cnt_d   = 4'd0;
                    acc_d   = '0;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    mac_a_d = a_vec;
                    mac_b_d = b_vec;
                    stage_d = 1'b1;
                    cnt_d   = w_cnt_inc;
                    if (w_cnt_inc == n_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d    = S_DONE;
                out_psum_d = w_res;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            n_q        <= 4'd0;
            cnt_q      <= 4'd0;
            stage_q    <= 1'b0;
            acc_q      <= '0;
            mac_a_q    <= '0;
            mac_b_q    <= '0;
            out_psum_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            acc_q      <= acc_d;
            mac_a_q    <= mac_a_d;
            mac_b_q    <= mac_b_d;
            out_psum_q <= out_psum_d;
        end
    end

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign out_psum  = out_psum_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Purpose  : Directed and randomized self-checking bench for mac_seq_ctrl,
//            including a behavioural model of the external MAC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_seq_ctrl;

    localparam int BW  = 8;
    localparam int PR  = 8;
    localparam int BWP = 2*BW+6;
    localparam int BWO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [3:0]       num_chunks;
    logic             in_valid;
    logic             in_ready;
    logic [PR*BW-1:0] a_vec, b_vec, mac_a, mac_b;
    logic [BWP-1:0]   mac_out;
    logic             out_valid;
    logic             out_ready;
    logic [BWO-1:0]   out_psum;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [63:0] ja [16];
    logic [63:0] jb [16];

    mac_seq_ctrl #(.bw(BW), .pr(PR), .bw_psum(BWP), .bw_out(BWO)) u_dut (
        .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
        .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
        .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External MAC: signed a lanes times unsigned b lanes, summed.
    always_comb begin
        logic signed [31:0] m;
        m = 0;
        for (int l = 0; l < PR; l++) begin
            m = m + $signed(mac_a[l*BW +: BW]) * $signed({1'b0, mac_b[l*BW +: BW]});
        end
        mac_out = m[BWP-1:0];
    end

    function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
        longint s;
        int av, bv;
        s = 0;
        for (int l = 0; l < PR; l++) begin
            av = $signed(a[l*BW +: BW]);
            bv = int'(b[l*BW +: BW]);
            s += longint'(av * bv);
        end
        return s;
    endfunction

    function automatic logic [15:0] fold(input longint s);
`ifdef ACC_SATURATE_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[15:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // mode: 0 continuous valid, 1 alternate bubbles, 2 random bubbles
    task automatic run_job(input int n, input int mode, input int hold);
        longint      sum;
        logic [15:0] exp;
        int          k, cyc;
        bit          v;
        sum = 0;
        for (int i = 0; i < n; i++) sum += dot(ja[i], jb[i]);
        exp = fold(sum);

        start = 1'b1; num_chunks = 4'(n);
        step();
        start = 1'b0;
        check("busy_acc", 64'(busy), 64'd1);

        k = 0; cyc = 0;
        while (k < n && cyc < 100) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            check("in_ready_acc", 64'(in_ready), 64'd1);
            in_valid = v;
            a_vec = v ? ja[k] : rnd64();
            b_vec = v ? jb[k] : rnd64();
            step();
            if (v) k++;
            cyc++;
        end
        in_valid = 1'b0;
        a_vec = rnd64(); b_vec = rnd64();
        check("beats_accepted", 64'(k), 64'(n));

        check("drain_in_ready", 64'(in_ready), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);
        check("drain_busy", 64'(busy), 64'd1);
        check("mac_a_last", mac_a, ja[n-1]);
        check("mac_b_last", mac_b, jb[n-1]);
        out_ready = (hold == 0);
        step();

        check("done_out_valid", 64'(out_valid), 64'd1);
        check("done_out_psum", 64'(out_psum), 64'(exp));
        check("done_in_ready", 64'(in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; start = 1'b1; num_chunks = 4'd5;
            step();
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_psum", 64'(out_psum), 64'(exp));
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_psum"}, 64'(out_psum), 64'd0);
        check({tag, "_mac_a"}, mac_a, 64'd0);
        check({tag, "_mac_b"}, mac_b, 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; num_chunks = 4'd0; in_valid = 1'b0;
        out_ready = 1'b0; a_vec = '0; b_vec = '0;
        step(); step();
        reset = 1'b0;
        check_reset_state("reset");

        // Zero-length job must not leave IDLE
        start = 1'b1; num_chunks = 4'd0;
        step();
        start = 1'b0;
        check("zero_chunks_busy", 64'(busy), 64'd0);

        // a=1, b=2, 3 beats -> 48
        for (int i = 0; i < 3; i++) begin ja[i] = 64'h0101010101010101; jb[i] = 64'h0202020202020202; end
        run_job(3, 0, 0);

        // a=-1, b=255, 1 beat -> -2040
        ja[0] = 64'hFFFFFFFFFFFFFFFF; jb[0] = 64'hFFFFFFFFFFFFFFFF;
        run_job(1, 0, 0);

        // Alternate bubbles, 4 beats
        for (int i = 0; i < 4; i++) begin ja[i] = rnd64(); jb[i] = rnd64(); end
        run_job(4, 1, 0);

        // Output back-pressure for 5 cycles
        for (int i = 0; i < 2; i++) begin ja[i] = rnd64(); jb[i] = rnd64(); end
        run_job(2, 0, 5);

        // Abort after 2 of 4 beats
        start = 1'b1; num_chunks = 4'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; a_vec = 64'h7F7F7F7F7F7F7F7F; b_vec = 64'hFFFFFFFFFFFFFFFF;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("abort");
        for (int i = 0; i < 3; i++) begin ja[i] = rnd64(); jb[i] = rnd64(); end
        run_job(3, 0, 0);

        // a=127, b=255, 1 beat: overflows the output width
        ja[0] = 64'h7F7F7F7F7F7F7F7F; jb[0] = 64'hFFFFFFFFFFFFFFFF;
        run_job(1, 0, 0);

        // Randomized jobs
        for (int j = 0; j < 8; j++) begin
            int n;
            n = $urandom_range(1, 15);
            for (int i = 0; i < n; i++) begin ja[i] = rnd64(); jb[i] = rnd64(); end
            run_job(n, 2, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter bw, default 8, operand width per lane.
REQ-002 SHALL have parameter pr, default 8, lanes per beat.
REQ-003 SHALL have parameter bw_psum, default 2*bw+6, width of the MAC datapath result.
REQ-004 SHALL have parameter bw_out, default 16, output result width.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, begins a job when sampled in IDLE.
REQ-008 SHALL have port num_chunks, input, 4, beats per job, latched on start.
REQ-009 SHALL have port in_valid, input, 1, operand beat valid.
REQ-010 SHALL have port in_ready, output, 1, beat accept.
REQ-011 SHALL have ports a_vec and b_vec, input, pr*bw each, packed lanes; a is signed, b is unsigned.
REQ-012 SHALL have ports mac_a and mac_b, output, pr*bw each, registered operands driven to the external combinational MAC.
REQ-013 SHALL have port mac_out, input, bw_psum, signed MAC result for the current mac_a/mac_b.
REQ-014 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_psum (output, bw_out, signed result).
REQ-015 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-016 SHALL implement the states IDLE, ACC, DRAIN and DONE.
REQ-017 SHALL leave IDLE for ACC when start=1 and num_chunks!=0, latching num_chunks, clearing the beat counter and clearing the accumulator.
REQ-018 SHALL stay in IDLE when start=1 with num_chunks=0.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL drive in_ready=1 only in ACC.
REQ-021 SHALL accept a beat when in_valid=1 and in_ready=1 in the same cycle.
REQ-022 SHALL, for an accepted beat, register a_vec/b_vec into mac_a/mac_b and set an internal stage-valid flag; mac_a/mac_b hold their value otherwise.
REQ-023 SHALL, in the cycle after an accepted beat, add sign-extended mac_out into the accumulator, width bw_psum+4.
REQ-024 SHALL treat in_valid=0 in ACC as a bubble: no count, no accumulate on the following cycle.
REQ-025 SHALL go ACC->DRAIN on acceptance of beat number num_chunks.
REQ-026 SHALL go DRAIN->DONE after exactly one cycle, once the last product is accumulated.
REQ-027 SHALL load out_psum from the accumulator on entry to DONE.
REQ-028 SHALL hold out_valid=1 and out_psum stable in DONE until out_ready=1, then go to IDLE, with out_valid low from the next cycle.
REQ-029 SHALL deliver out_valid 2 cycles after the last beat is accepted when out_ready is held 1.
REQ-030 SHALL allow a new start in the cycle after DONE->IDLE.

Reset
REQ-031 SHALL, when reset=1 at a clock edge, enter IDLE, clear the accumulator, beat counter and stage flag, and drive mac_a=0, mac_b=0, out_psum=0, out_valid=0, in_ready=0 and busy=0.
REQ-032 SHALL let reset override all other inputs in any state, including mid-job; no output is produced for an aborted job.

Configuration
REQ-033 SHALL, when ACC_SATURATE_EN is defined, clamp the accumulator to out_psum at the signed bw_out limits: 2^(bw_out-1)-1 and -2^(bw_out-1).
REQ-034 SHALL, when ACC_SATURATE_EN is undefined, truncate to the low bw_out bits, giving two's-complement wrap.

Verification
REQ-035 SHALL cover: all lanes a=1, b=2, num_chunks=3, continuous valid -> out_psum=48, out_valid 2 cycles after the 3rd beat.
REQ-036 SHALL cover: a=8'hFF (-1), b=255, num_chunks=1 -> out_psum=-2040 (16'hF808).
REQ-037 SHALL cover: num_chunks=4 with in_valid low on alternate cycles -> sum over exactly 4 beats, and in_ready=0 in DRAIN/DONE.
REQ-038 SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_valid and out_psum stable, start ignored, IDLE one cycle after out_ready=1.
REQ-039 SHALL cover: reset asserted after 2 of 4 beats -> IDLE, all outputs 0; a new job then gives a correct result with no leftover sum.
REQ-040 SHALL cover: a=127, b=255, 1 chunk (true sum 259080) -> 16'h7FFF with ACC_SATURATE_EN, 16'hF408 without.
